// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: chunk headers, default sizing and TX FSM states.
package serial_pkg;

  localparam logic [2:0] HDR_START = 3'b100;
  localparam logic [2:0] HDR_END   = 3'b111;

  localparam int unsigned NDefault          = 30;
  localparam int unsigned ClksPerBitDefault = 10417;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDone
  } tx_state_e;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with synchronous clear and a
// one-cycle tick on the last count of each bit period.
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART 8N1 transmitter: sends one n-bit chunk as BYTES bytes, most-significant byte first,
// LSB first within each byte, and counts completed chunks.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned n            = NDefault,
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n:1]   tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         txD,
  output logic         busy,
  output logic [9:0]   word_count
);

  localparam int unsigned BYTES = (n + 7) / 8;
  localparam int unsigned ShW   = 8 * BYTES;
  localparam int unsigned ByteW = (BYTES > 1) ? $clog2(BYTES) : 1;

  tx_state_e        state_q, state_d;
  logic [ShW-1:0]   shreg_q, shreg_d;
  logic [2:0]       bit_q, bit_d;
  logic [ByteW-1:0] byte_q, byte_d;
  logic [9:0]       wc_q, wc_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic       tick;
  logic       baud_clear;
  logic       accept;
  logic [7:0] cur_byte;

  assign accept   = tx_valid && ready_q;
  assign cur_byte = shreg_q[ShW-1 -: 8];

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    wc_d       = wc_q;
    txd_d      = txd_q;
    baud_clear = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        if (accept) begin
          // Clearing the baud timer here gives the first start bit its full width.
          state_d    = StStart;
          shreg_d    = ShW'(tx_data);
          bit_d      = '0;
          byte_d     = '0;
          baud_clear = 1'b1;
          txd_d      = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = '0;
          txd_d   = cur_byte[0];
        end
      end
      StData: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = cur_byte[bit_q + 3'd1];
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (byte_q == ByteW'(BYTES - 1)) begin
            state_d = StDone;
            wc_d    = wc_q + 10'd1;
            txd_d   = 1'b1;
          end else begin
            state_d = StStart;
            byte_d  = byte_q + ByteW'(1);
            shreg_d = shreg_q << 8;
            txd_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase

    ready_d = (state_d == StIdle) || (state_d == StDone);
    busy_d  = (state_d == StStart) || (state_d == StData) || (state_d == StStop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      wc_q    <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      wc_q    <= wc_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_ready   = ready_q;
  assign txD        = txd_q;
  assign busy       = busy_q;
  assign word_count = wc_q;

endmodule
